ddrx_init_sequencer: RTL and testbench
======================================

# ddrx_init_sequencer

Drives the DDRx power-up and mode-register initialisation sequence, using the mode-register values and timing parameters produced by the NASTILite configuration-register stage. It sits directly downstream of that stage. It also sits upstream of the controller's command path, which accepts one command per valid/ready handshake. Once `init_done` rises, the controller hands the DRAM over to normal scheduling.

## Interface
- `C_TIMER_WIDTH`, 10: width of the timing inputs and of the internal wait counter.
- `C_CKE_LOW_CYCLES`, 16: cycles CKE is held low after start, 1 to 2^20.
- `ddr_clk`  in  1  single clock; all logic on rising edge.
- `ddr_rst`  in  1  reset; synchronous, active-high.
- `init_start`  in  1  level; sampled only in IDLE.
- `cfg_msr0`..`cfg_msr3`  in  13 each  MR0–MR3 contents.
- `cfg_tXPR`, `cfg_tMRD`, `cfg_tMOD`, `cfg_tZQinit`  in  C_TIMER_WIDTH each  waits in `ddr_clk` cycles.
- `cke`  out  1  DRAM clock enable.
- `cmd_valid`  out  1  command valid.
- `cmd_ready`  in  1  downstream accepts the command.
- `cmd_type`  out  2  01 = MRS, 10 = ZQCL, 00 = none.
- `cmd_ba`  out  3  bank address.
- `cmd_addr`  out  16  address bus.
- `busy`  out  1  high from start acceptance until `init_done` rises.
- `init_done`  out  1  sticky completion flag.

## Operation
- **States:** IDLE, CKE_LOW, XPR_WAIT, CMD, CMD_WAIT, DONE. A step index 0–4 selects the current command.
- **Command order:**
  - step 0: MR2, `cmd_ba`=2, `cmd_addr`={3'b0,msr2}
  - step 1: MR3, `cmd_ba`=3, `cmd_addr`={3'b0,msr3}
  - step 2: MR1, `cmd_ba`=1, `cmd_addr`={3'b0,msr1}
  - step 3: MR0, `cmd_ba`=0, `cmd_addr`={3'b0,msr0}
  - step 4: ZQCL, `cmd_ba`=0, `cmd_addr`=16'h0400 (A10=1)
- **Wait after each command:** tMRD after steps 0–2, tMOD after step 3, tZQinit after step 4. A wait value of 0 is treated as 1 (effective wait = max(N,1)).
- **IDLE:** when `init_start`=1, all cfg inputs are latched into internal registers and the block moves to CKE_LOW. Changes to cfg inputs after this point are ignored until the next run.
- **CKE_LOW:** hold for C_CKE_LOW_CYCLES, then raise `cke` and enter XPR_WAIT.
- **XPR_WAIT:** wait max(tXPR,1) cycles, then enter CMD with step 0.
- **CMD:** assert `cmd_valid` with the step's payload. Hold payload and valid stable until the cycle where `cmd_valid` and `cmd_ready` are both high (the handshake).
- **After a handshake:**
  - `cmd_valid` drops the next cycle.
  - The wait timer starts at the handshake, not at first valid; stalls therefore never shorten a gap.
  - The block enters CMD_WAIT.
- **CMD_WAIT:** when the wait expires, go to CMD with step+1. After step 4's wait, go to DONE.
- **DONE:** `init_done`=1, `busy`=0, `cke` stays 1. `init_start` is ignored. DONE is left only via reset.
- `cmd_type`, `cmd_ba` and `cmd_addr` are driven to 0 whenever `cmd_valid`=0.

## Timing
- **Reset values:** `cke`=0, `cmd_valid`=0, `cmd_type`=0, `cmd_ba`=0, `cmd_addr`=0, `busy`=0, `init_done`=0, state IDLE.
- **Reset has priority over everything, including mid-sequence or mid-handshake.** Outputs show reset values in the cycle after `ddr_rst` is sampled high. A pending command is dropped, not completed.
- Let cycle s be the cycle in which `init_start` is sampled high in IDLE:
  - `busy`=1 from s+1.
  - `cke`=1 from cycle s+C_CKE_LOW_CYCLES.
  - First `cmd_valid` (MR2) at s+C_CKE_LOW_CYCLES+max(tXPR,1).
- If a handshake occurs at cycle k with wait N, the next `cmd_valid` or `init_done` rises at exactly k+max(N,1).
- Setting `init_start`=1 in the same cycle as `ddr_rst`=1 has no effect; the block stays in IDLE.
- All outputs are registered. `cmd_ready` has no combinational path to any output.

## Test plan
- **Nominal run.** C_CKE_LOW_CYCLES=16, tXPR=5, tMRD=4, tMOD=12, tZQinit=20, `cmd_ready`=1, start at cycle 0. Required:
  - `cke` rises at 16.
  - Handshakes: MR2@21, MR3@25, MR1@29, MR0@33, ZQCL@45.
  - `init_done` rises at 65; `busy` falls at 65.
  - Payloads as listed under Operation, with msr values passed through.
- **Backpressure.** Same setup, `cmd_ready`=0 during cycles 25–27. Required: MR3 payload held stable, MR3 handshake at 28, MR1@32, MR0@36, ZQCL@48, `init_done`@68.
- **Zero waits.** tXPR=tMRD=tMOD=tZQinit=0. Required: MR2 at 17, then commands in consecutive cycles 17–21, `init_done` at 22.
- **Config change mid-run.** Change `cfg_msr0` and `cfg_tMOD` at cycle 22 of the nominal run. Required: MR0 carries the value latched at start, and ZQCL still handshakes at 45.
- **Reset mid-operation.** Assert `ddr_rst` at cycle 30. Required:
  - All outputs at reset values at cycle 31.
  - A new start at cycle 40 reproduces the nominal sequence offset by 40.
- **DONE stability.** After `init_done`, pulse `init_start` for 10 cycles. Required: no `cmd_valid`, and `init_done` and `cke` remain 1.

Source files
------------

// File: rtl/ddrx_init_sequencer.sv
// DDRx power-up sequencer: CKE low hold, tXPR wait, MR2/MR3/MR1/MR0 then ZQCL,
// each followed by its timing gap measured from the command handshake.
module ddrx_init_sequencer #(
    parameter int C_TIMER_WIDTH    = 10,
    parameter int C_CKE_LOW_CYCLES = 16
) (
    input  logic                     ddr_clk,
    input  logic                     ddr_rst,
    input  logic                     init_start,
    input  logic [12:0]              cfg_msr0,
    input  logic [12:0]              cfg_msr1,
    input  logic [12:0]              cfg_msr2,
    input  logic [12:0]              cfg_msr3,
    input  logic [C_TIMER_WIDTH-1:0] cfg_tXPR,
    input  logic [C_TIMER_WIDTH-1:0] cfg_tMRD,
    input  logic [C_TIMER_WIDTH-1:0] cfg_tMOD,
    input  logic [C_TIMER_WIDTH-1:0] cfg_tZQinit,
    output logic                     cke,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [1:0]               cmd_type,
    output logic [2:0]               cmd_ba,
    output logic [15:0]              cmd_addr,
    output logic                     busy,
    output logic                     init_done
);
    localparam int TW = C_TIMER_WIDTH;
    localparam int CW = $clog2(C_CKE_LOW_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CKE_LOW, S_XPR_WAIT, S_CMD, S_CMD_WAIT, S_DONE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_step;
    logic [TW-1:0] r_cnt;
    logic [CW-1:0] r_cke_cnt;
    logic [12:0]   r_msr0, r_msr1, r_msr2, r_msr3;
    logic [TW-1:0] r_txpr, r_tmrd, r_tmod, r_tzq;

    logic [2:0]    w_sel_step;
    logic [1:0]    w_type;
    logic [2:0]    w_ba;
    logic [15:0]   w_addr;
    logic [TW-1:0] w_wait;
    logic [TW-1:0] w_wait_eff;
    logic          w_adv;

    function automatic logic [TW-1:0] f_eff(input logic [TW-1:0] v);
        return (v == '0) ? TW'(1) : v;
    endfunction

    // Payload for the command about to be issued: step 0 out of XPR_WAIT, else step+1
    assign w_sel_step = (r_state == S_XPR_WAIT) ? 3'd0 : 3'(r_step + 3'd1);

    always_comb begin
        w_type = 2'b01;
        w_ba   = 3'd0;
        w_addr = 16'h0000;
        case (w_sel_step)
            3'd0: begin w_ba = 3'd2; w_addr = {3'b000, r_msr2}; end
            3'd1: begin w_ba = 3'd3; w_addr = {3'b000, r_msr3}; end
            3'd2: begin w_ba = 3'd1; w_addr = {3'b000, r_msr1}; end
            3'd3: begin w_ba = 3'd0; w_addr = {3'b000, r_msr0}; end
            default: begin w_type = 2'b10; w_addr = 16'h0400; end
        endcase
    end

    always_comb begin
        w_wait = r_tmrd;
        if (r_step == 3'd3) w_wait = r_tmod;
        else if (r_step == 3'd4) w_wait = r_tzq;
    end

    assign w_wait_eff = f_eff(w_wait);

    // A one-cycle gap skips CMD_WAIT so back-to-back commands stay valid
    assign w_adv = ((r_state == S_CMD) && cmd_ready && (w_wait_eff == TW'(1)))
                || ((r_state == S_CMD_WAIT) && (r_cnt == '0));

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            r_state   <= S_IDLE;
            r_step    <= 3'd0;
            r_cnt     <= '0;
            r_cke_cnt <= '0;
            cke       <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_type  <= 2'b00;
            cmd_ba    <= 3'd0;
            cmd_addr  <= 16'h0000;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else if (w_adv) begin
            if (r_step == 3'd4) begin
                r_state   <= S_DONE;
                cmd_valid <= 1'b0;
                cmd_type  <= 2'b00;
                cmd_ba    <= 3'd0;
                cmd_addr  <= 16'h0000;
                busy      <= 1'b0;
                init_done <= 1'b1;
            end else begin
                r_state   <= S_CMD;
                r_step    <= w_sel_step;
                cmd_valid <= 1'b1;
                cmd_type  <= w_type;
                cmd_ba    <= w_ba;
                cmd_addr  <= w_addr;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init_start) begin
                        r_msr0 <= cfg_msr0;
                        r_msr1 <= cfg_msr1;
                        r_msr2 <= cfg_msr2;
                        r_msr3 <= cfg_msr3;
                        r_txpr <= cfg_tXPR;
                        r_tmrd <= cfg_tMRD;
                        r_tmod <= cfg_tMOD;
                        r_tzq  <= cfg_tZQinit;
                        busy   <= 1'b1;
                        if (C_CKE_LOW_CYCLES == 1) begin
                            cke     <= 1'b1;
                            r_cnt   <= f_eff(cfg_tXPR) - TW'(1);
                            r_state <= S_XPR_WAIT;
                        end else begin
                            r_cke_cnt <= CW'(C_CKE_LOW_CYCLES - 1);
                            r_state   <= S_CKE_LOW;
                        end
                    end
                end
                S_CKE_LOW: begin
                    if (r_cke_cnt == CW'(1)) begin
                        cke     <= 1'b1;
                        r_cnt   <= f_eff(r_txpr) - TW'(1);
                        r_state <= S_XPR_WAIT;
                    end else begin
                        r_cke_cnt <= r_cke_cnt - CW'(1);
                    end
                end
                S_XPR_WAIT: begin
                    if (r_cnt == '0) begin
                        r_step    <= 3'd0;
                        cmd_valid <= 1'b1;
                        cmd_type  <= w_type;
                        cmd_ba    <= w_ba;
                        cmd_addr  <= w_addr;
                        r_state   <= S_CMD;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_CMD: begin
                    if (cmd_ready) begin
                        r_cnt     <= w_wait_eff - TW'(2);
                        cmd_valid <= 1'b0;
                        cmd_type  <= 2'b00;
                        cmd_ba    <= 3'd0;
                        cmd_addr  <= 16'h0000;
                        r_state   <= S_CMD_WAIT;
                    end
                end
                S_CMD_WAIT: r_cnt <= r_cnt - TW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddrx_init_sequencer.sv
// Bench for ddrx_init_sequencer: spec vector table, hand-written reset/DONE
// sequences and randomized runs against an event-timing reference model.
module tb_ddrx_init_sequencer;
    localparam int CKE = 16;

    logic        ddr_clk = 1'b0;
    logic        ddr_rst = 1'b1;
    logic        init_start = 1'b0;
    logic [12:0] cfg_msr0 = '0, cfg_msr1 = '0, cfg_msr2 = '0, cfg_msr3 = '0;
    logic [9:0]  cfg_tXPR = '0, cfg_tMRD = '0, cfg_tMOD = '0, cfg_tZQinit = '0;
    logic        cke, cmd_valid, busy, init_done;
    logic        cmd_ready = 1'b1;
    logic [1:0]  cmd_type;
    logic [2:0]  cmd_ba;
    logic [15:0] cmd_addr;

    ddrx_init_sequencer #(.C_TIMER_WIDTH(10), .C_CKE_LOW_CYCLES(CKE)) dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .init_start(init_start),
        .cfg_msr0(cfg_msr0), .cfg_msr1(cfg_msr1),
        .cfg_msr2(cfg_msr2), .cfg_msr3(cfg_msr3),
        .cfg_tXPR(cfg_tXPR), .cfg_tMRD(cfg_tMRD),
        .cfg_tMOD(cfg_tMOD), .cfg_tZQinit(cfg_tZQinit),
        .cke(cke), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .busy(busy), .init_done(init_done)
    );

    always #5 ddr_clk = ~ddr_clk;

    typedef int a5_t[5];
    typedef struct {
        int xpr, mrd, mod, zq, lo, hi, chg;
        int h0, h1, h2, h3, h4, done;
    } vec_t;

    int  n_tests = 0;
    int  n_fail = 0;
    bit  rdy_pat[0:1023];
    int  first_bad;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mx1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Expected command payload {type, ba, addr} for command number i
    function automatic logic [20:0] exp_pay(input int i, input logic [12:0] m0,
            input logic [12:0] m1, input logic [12:0] m2, input logic [12:0] m3);
        case (i)
            0: return {2'b01, 3'd2, 3'b000, m2};
            1: return {2'b01, 3'd3, 3'b000, m3};
            2: return {2'b01, 3'd1, 3'b000, m1};
            3: return {2'b01, 3'd0, 3'b000, m0};
            default: return {2'b10, 3'd0, 16'h0400};
        endcase
    endfunction

    // Reference timeline: each command is offered at t, accepted at the first
    // ready cycle, and the next one is offered max(gap,1) after acceptance.
    task automatic model(input int xpr, input int mrd, input int mod, input int zq,
            output a5_t first, output a5_t hs, output int done);
        int t, h;
        t = CKE + mx1(xpr);
        for (int i = 0; i < 5; i++) begin
            first[i] = t;
            h = t;
            while (!rdy_pat[h] && h < 1000) h++;
            hs[i] = h;
            t = h + mx1((i < 3) ? mrd : (i == 3) ? mod : zq);
        end
        done = t;
    endtask

    task automatic run(input bit do_rst, input int xpr, input int mrd, input int mod,
            input int zq, input logic [12:0] m0, input logic [12:0] m1,
            input logic [12:0] m2, input logic [12:0] m3, input int chg,
            output a5_t ohs, output int odone, output int obad);
        a5_t mf, mh;
        int md, idx;
        logic [20:0] pay;
        logic [24:0] act, exp;
        if (do_rst) begin
            ddr_rst = 1'b1;
            @(posedge ddr_clk); #1;
            ddr_rst = 1'b0;
        end
        cfg_msr0 = m0; cfg_msr1 = m1; cfg_msr2 = m2; cfg_msr3 = m3;
        cfg_tXPR = 10'(xpr); cfg_tMRD = 10'(mrd);
        cfg_tMOD = 10'(mod); cfg_tZQinit = 10'(zq);
        model(xpr, mrd, mod, zq, mf, mh, md);
        for (int i = 0; i < 5; i++) ohs[i] = -1;
        odone = -1; obad = 0; idx = 0; first_bad = -1;
        for (int c = 0; c <= md + 4; c++) begin
            init_start = (c == 0);
            cmd_ready = rdy_pat[c];
            if (c == chg) begin
                cfg_msr0 = ~m0;
                cfg_tMOD = 10'(mod + 7);
            end
            @(negedge ddr_clk);
            pay = '0;
            exp[24] = 1'b0;
            for (int i = 0; i < 5; i++)
                if (c >= mf[i] && c <= mh[i]) begin
                    exp[24] = 1'b1;
                    pay = exp_pay(i, m0, m1, m2, m3);
                end
            exp[23:0] = {pay, c >= CKE, c >= 1 && c < md, c >= md};
            act = {cmd_valid, cmd_type, cmd_ba, cmd_addr, cke, busy, init_done};
            if (act !== exp) begin
                obad++;
                if (first_bad < 0) first_bad = c;
            end
            if (cmd_valid && cmd_ready && idx < 5) begin
                ohs[idx] = c;
                idx++;
            end
            if (init_done && odone < 0) odone = c;
            @(posedge ddr_clk); #1;
        end
        init_start = 1'b0;
        cmd_ready = 1'b1;
    endtask

    vec_t tbl[4];
    a5_t  hs;
    int   done, bad, cnt;

    initial begin
        tbl[0] = '{5, 4, 12, 20, -1, -2, -1, 21, 25, 29, 33, 45, 65};
        tbl[1] = '{5, 4, 12, 20, 25, 27, -1, 21, 28, 32, 36, 48, 68};
        tbl[2] = '{0, 0, 0, 0, -1, -2, -1, 17, 18, 19, 20, 21, 22};
        tbl[3] = '{5, 4, 12, 20, -1, -2, 22, 21, 25, 29, 33, 45, 65};

        repeat (2) @(posedge ddr_clk);
        #1;
        ddr_rst = 1'b0;
        @(negedge ddr_clk);
        check("reset_state",
              int'({cke, cmd_valid, cmd_type, cmd_ba, cmd_addr, busy, init_done}), 0);
        @(posedge ddr_clk); #1;

        foreach (tbl[k]) begin
            for (int c = 0; c < 1024; c++)
                rdy_pat[c] = !(c >= tbl[k].lo && c <= tbl[k].hi);
            run(1'b1, tbl[k].xpr, tbl[k].mrd, tbl[k].mod, tbl[k].zq,
                13'h0520, 13'h0044, 13'h0018, 13'h0004, tbl[k].chg, hs, done, bad);
            check($sformatf("vec%0d_hs_mr2", k), hs[0], tbl[k].h0);
            check($sformatf("vec%0d_hs_mr3", k), hs[1], tbl[k].h1);
            check($sformatf("vec%0d_hs_mr1", k), hs[2], tbl[k].h2);
            check($sformatf("vec%0d_hs_mr0", k), hs[3], tbl[k].h3);
            check($sformatf("vec%0d_hs_zqcl", k), hs[4], tbl[k].h4);
            check($sformatf("vec%0d_done", k), done, tbl[k].done);
            check($sformatf("vec%0d_cycles_bad(first %0d)", k, first_bad), bad, 0);
        end

        // Reset in the middle of the sequence, then a fresh start at cycle 40
        for (int c = 0; c < 1024; c++) rdy_pat[c] = 1'b1;
        ddr_rst = 1'b1;
        @(posedge ddr_clk); #1;
        ddr_rst = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            init_start = (c == 0);
            ddr_rst = (c == 30);
            @(posedge ddr_clk); #1;
        end
        ddr_rst = 1'b0;
        init_start = 1'b0;
        @(negedge ddr_clk);
        check("reset_mid_outputs",
              int'({cke, cmd_valid, cmd_type, cmd_ba, cmd_addr, busy, init_done}), 0);
        @(posedge ddr_clk); #1;
        for (int c = 32; c < 40; c++) begin
            @(posedge ddr_clk); #1;
        end
        run(1'b0, 5, 4, 12, 20, 13'h0520, 13'h0044, 13'h0018, 13'h0004, -1,
            hs, done, bad);
        check("restart_hs_mr2", hs[0], 21);
        check("restart_hs_zqcl", hs[4], 45);
        check("restart_done", done, 65);
        check($sformatf("restart_cycles_bad(first %0d)", first_bad), bad, 0);

        // DONE must ignore further start requests
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            init_start = 1'b1;
            @(negedge ddr_clk);
            if ({cmd_valid, init_done, cke, busy} !== 4'b0110) cnt++;
            @(posedge ddr_clk); #1;
        end
        init_start = 1'b0;
        check("done_stable_bad_cycles", cnt, 0);

        // Start coincident with reset is discarded
        ddr_rst = 1'b1;
        init_start = 1'b1;
        @(posedge ddr_clk); #1;
        ddr_rst = 1'b0;
        init_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge ddr_clk);
            if ({cke, busy, cmd_valid, init_done} !== 4'b0000) cnt++;
            @(posedge ddr_clk); #1;
        end
        check("start_with_reset_bad_cycles", cnt, 0);

        for (int r = 0; r < 10; r++) begin
            int xpr, mrd, mod, zq, chg;
            a5_t mf, mh;
            int md;
            logic [12:0] m0, m1, m2, m3;
            for (int c = 0; c < 1024; c++) rdy_pat[c] = ($urandom_range(0, 9) < 7);
            xpr = $urandom_range(0, 10);
            mrd = $urandom_range(0, 8);
            mod = $urandom_range(0, 15);
            zq  = $urandom_range(0, 25);
            chg = $urandom_range(1, 60);
            m0 = 13'($urandom); m1 = 13'($urandom);
            m2 = 13'($urandom); m3 = 13'($urandom);
            model(xpr, mrd, mod, zq, mf, mh, md);
            run(1'b1, xpr, mrd, mod, zq, m0, m1, m2, m3, chg, hs, done, bad);
            check($sformatf("rand%0d_done", r), done, md);
            check($sformatf("rand%0d_hs_zqcl", r), hs[4], mh[4]);
            check($sformatf("rand%0d_cycles_bad(first %0d)", r, first_bad), bad, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
